// File: rtl/calc_key_sequencer.sv
// rtl/calc_key_sequencer.sv - calculator keypad sequencer feeding a two-operand ALU
//
// Ports:
//   clk         system clock, all state changes on the rising edge
//   clear       synchronous active-high reset
//   key_valid   one-cycle strobe qualifying key_code
//   key_code    0-9 digit, 10 add, 11 sub, 12 mul, 13 div, 14 equals, 15 clear-entry
//   result      ALU result, valid from the cycle after exec
//   num_a       first operand to ALU (registered)
//   num_b       second operand to ALU (registered)
//   opcode      ALU opcode, 10-13 only (registered)
//   exec        one-cycle calculation request, coincident with entry to DONE
//   err         divide-by-zero rejection flag
//   disp_value  value to display (registered)
//   state       0 ENTER_A, 1 ENTER_B, 2 DONE
module calc_key_sequencer #(
    parameter int MAX_DIGITS = 4
) (
    input  logic        clk,
    input  logic        clear,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    input  logic [15:0] result,
    output logic [15:0] num_a,
    output logic [15:0] num_b,
    output logic [3:0]  opcode,
    output logic        exec,
    output logic        err,
    output logic [15:0] disp_value,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        ENTER_A = 2'd0,
        ENTER_B = 2'd1,
        DONE    = 2'd2
    } state_t;

    localparam logic [2:0] MAX_CNT = 3'(MAX_DIGITS);
    localparam logic [3:0] KEY_ADD = 4'd10;
    localparam logic [3:0] KEY_DIV = 4'd13;
    localparam logic [3:0] KEY_EQ  = 4'd14;
    localparam logic [3:0] KEY_CE  = 4'd15;

    state_t      cur_state, nxt_state;
    logic [15:0] num_a_n, num_b_n, disp_n;
    logic [2:0]  cnt_a, cnt_b, cnt_a_n, cnt_b_n;
    logic [3:0]  opcode_n;
    logic        exec_n, err_n;
    logic        is_digit, is_op;
    logic [15:0] digit_val;

    assign is_digit  = (key_code <= 4'd9);
    assign is_op     = (key_code >= KEY_ADD) && (key_code <= KEY_DIV);
    assign digit_val = {12'd0, key_code};

    always_comb begin
        nxt_state = cur_state;
        num_a_n   = num_a;
        num_b_n   = num_b;
        cnt_a_n   = cnt_a;
        cnt_b_n   = cnt_b;
        opcode_n  = opcode;
        exec_n    = 1'b0;
        err_n     = err;

        if (key_valid) begin
            // Any accepted key retires a pending divide-by-zero flag.
            err_n = 1'b0;
            case (cur_state)
                ENTER_A: begin
                    if (is_digit) begin
                        if (cnt_a < MAX_CNT) begin
                            num_a_n = num_a * 16'd10 + digit_val;
                            cnt_a_n = cnt_a + 3'd1;
                        end
                    end else if (is_op) begin
                        opcode_n  = key_code;
                        num_b_n   = 16'd0;
                        cnt_b_n   = 3'd0;
                        nxt_state = ENTER_B;
                    end else if (key_code == KEY_CE) begin
                        num_a_n = 16'd0;
                        cnt_a_n = 3'd0;
                    end
                end
                ENTER_B: begin
                    if (is_digit) begin
                        if (cnt_b < MAX_CNT) begin
                            num_b_n = num_b * 16'd10 + digit_val;
                            cnt_b_n = cnt_b + 3'd1;
                        end
                    end else if (is_op) begin
                        // Operator may only be swapped before any B digit is typed.
                        if (cnt_b == 3'd0) begin
                            opcode_n = key_code;
                        end
                    end else if (key_code == KEY_EQ) begin
                        if (cnt_b != 3'd0) begin
                            if (opcode == KEY_DIV && num_b == 16'd0) begin
                                err_n = 1'b1;
                            end else begin
                                exec_n    = 1'b1;
                                nxt_state = DONE;
                            end
                        end
                    end else begin
                        num_b_n = 16'd0;
                        cnt_b_n = 3'd0;
                    end
                end
                DONE: begin
                    if (is_digit) begin
                        num_a_n   = digit_val;
                        cnt_a_n   = 3'd1;
                        num_b_n   = 16'd0;
                        cnt_b_n   = 3'd0;
                        nxt_state = ENTER_A;
                    end else if (is_op) begin
                        // Chaining: the previous result becomes a full-length A operand.
                        num_a_n   = result;
                        cnt_a_n   = MAX_CNT;
                        opcode_n  = key_code;
                        num_b_n   = 16'd0;
                        cnt_b_n   = 3'd0;
                        nxt_state = ENTER_B;
                    end else if (key_code == KEY_CE) begin
                        num_a_n   = 16'd0;
                        cnt_a_n   = 3'd0;
                        num_b_n   = 16'd0;
                        cnt_b_n   = 3'd0;
                        nxt_state = ENTER_A;
                    end
                end
                default: nxt_state = ENTER_A;
            endcase
        end
    end

    // Display follows the post-key operands; in DONE it tracks the live ALU result.
    always_comb begin
        disp_n = 16'd0;
        case (nxt_state)
            ENTER_A: disp_n = num_a_n;
            ENTER_B: disp_n = (cnt_b_n != 3'd0) ? num_b_n : num_a_n;
            DONE:    disp_n = result;
            default: disp_n = 16'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            cur_state  <= ENTER_A;
            num_a      <= 16'd0;
            num_b      <= 16'd0;
            cnt_a      <= 3'd0;
            cnt_b      <= 3'd0;
            opcode     <= KEY_ADD;
            exec       <= 1'b0;
            err        <= 1'b0;
            disp_value <= 16'd0;
        end else begin
            cur_state  <= nxt_state;
            num_a      <= num_a_n;
            num_b      <= num_b_n;
            cnt_a      <= cnt_a_n;
            cnt_b      <= cnt_b_n;
            opcode     <= opcode_n;
            exec       <= exec_n;
            err        <= err_n;
            disp_value <= disp_n;
        end
    end

    assign state = cur_state;

endmodule

// File: tb/tb_calc_key_sequencer.sv
// tb/tb_calc_key_sequencer.sv - directed scoreboard bench for calc_key_sequencer
module tb_calc_key_sequencer;

    logic        clk = 1'b0;
    logic        clear = 1'b0;
    logic        key_valid = 1'b0;
    logic [3:0]  key_code = 4'd0;
    logic [15:0] result = 16'd0;
    logic [15:0] num_a, num_b, disp_value;
    logic [3:0]  opcode;
    logic        exec, err;
    logic [1:0]  state;

    int checks = 0;
    int failures = 0;
    int exec_seen = 0;
    logic [35:0] exp_q[$];

    calc_key_sequencer #(.MAX_DIGITS(4)) dut (
        .clk(clk), .clear(clear), .key_valid(key_valid), .key_code(key_code),
        .result(result), .num_a(num_a), .num_b(num_b), .opcode(opcode),
        .exec(exec), .err(err), .disp_value(disp_value), .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Each exec pulse pops the operand/opcode triple pushed when its equals key was driven.
    always @(negedge clk) begin
        if (exec === 1'b1) begin
            exec_seen++;
            if (exp_q.size() == 0) begin
                checks++;
                assert (0) else begin
                    failures++;
                    $error("FAIL unexpected_exec observed=1 expected=0");
                end
            end else begin
                chk("exec_operands", {num_a, opcode, num_b}, exp_q.pop_front());
            end
        end
    end

    task automatic press(input logic [3:0] k);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = k;
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_num_a"}, 36'(num_a), 36'd0);
        chk({tag, "_num_b"}, 36'(num_b), 36'd0);
        chk({tag, "_opcode"}, 36'(opcode), 36'd10);
        chk({tag, "_exec"}, 36'(exec), 36'd0);
        chk({tag, "_err"}, 36'(err), 36'd0);
        chk({tag, "_disp"}, 36'(disp_value), 36'd0);
        chk({tag, "_state"}, 36'(state), 36'd0);
    endtask

    initial begin
        // Reset asserted together with a key: key must be ignored.
        key_valid = 1'b1;
        key_code  = 4'd7;
        clear     = 1'b1;
        @(negedge clk);
        @(negedge clk);
        clear     = 1'b0;
        key_valid = 1'b0;
        chk_reset("reset");

        // 12 + 34
        press(4'd1);
        press(4'd2);
        chk("a12_disp", 36'(disp_value), 36'd12);
        press(4'd10);
        chk("op_state", 36'(state), 36'd1);
        chk("op_disp_a", 36'(disp_value), 36'd12);
        press(4'd3);
        press(4'd4);
        chk("b34_disp", 36'(disp_value), 36'd34);
        exp_q.push_back({16'd12, 4'd10, 16'd34});
        press(4'd14);
        chk("eq_state", 36'(state), 36'd2);
        result = 16'd46;
        @(negedge clk);
        @(negedge clk);
        chk("done_disp", 36'(disp_value), 36'd46);
        press(4'd14);
        chk("done_eq_ignored", 36'(state), 36'd2);
        chk("done_stable", {num_a, opcode, num_b}, {16'd12, 4'd10, 16'd34});

        // Chaining from result 46: 46 - 6
        press(4'd11);
        chk("chain_state", 36'(state), 36'd1);
        chk("chain_num_a", 36'(num_a), 36'd46);
        chk("chain_opcode", 36'(opcode), 36'd11);
        chk("chain_num_b", 36'(num_b), 36'd0);
        press(4'd6);
        exp_q.push_back({16'd46, 4'd11, 16'd6});
        press(4'd14);
        chk("chain_done", 36'(state), 36'd2);

        // Digit from DONE starts fresh, fifth digit ignored, then clear-entry
        for (int i = 0; i < 5; i++) press(4'd9);
        chk("max_digits", 36'(num_a), 36'd9999);
        chk("max_state", 36'(state), 36'd0);
        chk("max_num_b", 36'(num_b), 36'd0);
        press(4'd15);
        chk("ce_num_a", 36'(num_a), 36'd0);
        chk("ce_state", 36'(state), 36'd0);

        // Leading zeros consume digit slots: 0,0,5,1,2 -> 51
        press(4'd0);
        press(4'd0);
        press(4'd5);
        chk("lead_zero_val", 36'(num_a), 36'd5);
        press(4'd1);
        press(4'd2);
        chk("lead_zero_cnt", 36'(num_a), 36'd51);

        // Divide by zero rejected, err clears on next key
        do_clear();
        press(4'd8);
        press(4'd13);
        press(4'd0);
        press(4'd14);
        chk("dz_err", 36'(err), 36'd1);
        chk("dz_state", 36'(state), 36'd1);
        press(4'd2);
        chk("dz_err_clr", 36'(err), 36'd0);
        chk("dz_num_b", 36'(num_b), 36'd2);
        exp_q.push_back({16'd8, 4'd13, 16'd2});
        press(4'd14);
        chk("dz_done", 36'(state), 36'd2);

        // Operator replacement, equals with empty B ignored, idle key_code toggling
        do_clear();
        press(4'd14);
        chk("eq_in_a_ignored", 36'(state), 36'd0);
        press(4'd5);
        press(4'd10);
        press(4'd12);
        chk("op_replace", 36'(opcode), 36'd12);
        press(4'd14);
        chk("eq_empty_b", 36'(state), 36'd1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            key_code = 4'(i * 3);
        end
        chk("idle_state", 36'(state), 36'd1);
        chk("idle_regs", {num_a, opcode, num_b}, {16'd5, 4'd12, 16'd0});
        press(4'd3);
        press(4'd11);
        chk("op_locked", 36'(opcode), 36'd12);
        chk("disp_b", 36'(disp_value), 36'd3);

        // Clear in the exec cycle: exec drops, no second pulse
        do_clear();
        press(4'd1);
        press(4'd10);
        press(4'd2);
        exp_q.push_back({16'd1, 4'd10, 16'd2});
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = 4'd14;
        @(negedge clk);
        key_valid = 1'b0;
        clear     = 1'b1;
        @(negedge clk);
        clear     = 1'b0;
        chk_reset("clr_exec");
        repeat (4) @(negedge clk);

        // Clear mid-entry
        press(4'd7);
        press(4'd10);
        chk("mid_state", 36'(state), 36'd1);
        do_clear();
        chk_reset("mid_clr");

        chk("exec_count", 36'(exec_seen), 36'd4);
        chk("queue_empty", 36'(exp_q.size()), 36'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
